// File: rtl/ps2_pkg.sv
// Purpose: shared scancode constants, parser state type and prefix helpers for the PS/2 key decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    // Prefix and modifier scancodes (PS/2 set 2)
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ENTER  = 8'h5A;

    // Keyboard status/protocol bytes that never carry a keystroke
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_RESEND = 8'hFE;

    localparam logic [7:0] ASCII_CR  = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } parse_state_t;

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == SC_BAT_OK) || (b == SC_ACK) || (b == SC_ECHO) || (b == SC_RESEND);
    endfunction

endpackage

// File: rtl/ps2_set2_ascii.sv
// Purpose: combinational PS/2 set-2 make code to ASCII map with Shift/Caps case rules.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: code = make code, shift = either Shift held, caps = Caps Lock state,
//        ascii = mapped character, 0x00 when the code has no printable/control meaning.
module ps2_set2_ascii (
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);

    logic [7:0]  letter;   // lowercase letter, 0 when code is not a letter
    logic [15:0] pair;     // {shifted glyph, plain glyph} for non-letters

    always_comb begin
        letter = 8'h00;
        case (code)
            8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";
            8'h23: letter = "d";  8'h24: letter = "e";  8'h2B: letter = "f";
            8'h34: letter = "g";  8'h33: letter = "h";  8'h43: letter = "i";
            8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
            8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";
            8'h4D: letter = "p";  8'h15: letter = "q";  8'h2D: letter = "r";
            8'h1B: letter = "s";  8'h2C: letter = "t";  8'h3C: letter = "u";
            8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
            8'h35: letter = "y";  8'h1A: letter = "z";
            default: letter = 8'h00;
        endcase
    end

    always_comb begin
        pair = 16'h0000;
        case (code)
            8'h16: pair = {"!", "1"};  8'h1E: pair = {"@", "2"};
            8'h26: pair = {"#", "3"};  8'h25: pair = {"$", "4"};
            8'h2E: pair = {"%", "5"};  8'h36: pair = {"^", "6"};
            8'h3D: pair = {"&", "7"};  8'h3E: pair = {"*", "8"};
            8'h46: pair = {"(", "9"};  8'h45: pair = {")", "0"};
            8'h4E: pair = {"_", "-"};  8'h55: pair = {"+", "="};
            8'h54: pair = {"{", "["};  8'h5B: pair = {"}", "]"};
            8'h4C: pair = {":", ";"};  8'h52: pair = {8'h22, 8'h27};
            8'h41: pair = {"<", ","};  8'h49: pair = {">", "."};
            8'h4A: pair = {"?", "/"};  8'h0E: pair = {8'h7E, 8'h60};
            // Control keys ignore Shift
            8'h29: pair = {8'h20, 8'h20};
            8'h5A: pair = {8'h0D, 8'h0D};
            8'h66: pair = {8'h08, 8'h08};
            8'h0D: pair = {8'h09, 8'h09};
            default: pair = 16'h0000;
        endcase
    end

    always_comb begin
        ascii = 8'h00;
        if (letter != 8'h00) begin
            // Caps Lock inverts Shift for letters only
            ascii = (shift ^ caps) ? (letter - 8'h20) : letter;
        end else begin
            ascii = shift ? pair[15:8] : pair[7:0];
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Purpose: PS/2 set-2 scancode parser (make/break/extended, Shift, Caps Lock) feeding an FWFT ASCII FIFO.
// Latency: 1 cycle from accepted make byte to out_valid/out_ascii.
// Backpressure: out_ready pops the head; when the FIFO is full and not popping, characters drop and overflow sticks.
// Ports: clk/reset (async active-low); rx_data/read_data/err = byte strobe from the PS/2 receiver;
//        out_ascii/out_valid/out_ready = character stream; shift_active, caps_lock, overflow, fifo_count = status.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             read_data,
    input  logic             err,
    output logic [7:0]       out_ascii,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             shift_active,
    output logic             caps_lock,
    output logic             overflow,
    output logic [CNT_W-1:0] fifo_count
);

    import ps2_pkg::*;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    parse_state_t     state_q, state_d;
    logic             lshift_q, lshift_d;
    logic             rshift_q, rshift_d;
    logic             caps_lock_q, caps_lock_d;
    logic             caps_held_q, caps_held_d;
    logic             overflow_q, overflow_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [7:0]       head_q, head_d;

    logic [7:0]       map_ascii;
    logic             push;
    logic [7:0]       push_dat;
    logic             pop;
    logic             full;
    logic             push_ok;
    logic [CNT_W-1:0] count_after_pop;

    ps2_set2_ascii u_map (
        .code  (rx_data),
        .shift (lshift_q | rshift_q),
        .caps  (caps_lock_q),
        .ascii (map_ascii)
    );

    // Parser and modifier tracking
    always_comb begin
        state_d     = state_q;
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        caps_lock_d = caps_lock_q;
        caps_held_d = caps_held_q;
        push        = 1'b0;
        push_dat    = map_ascii;

        if (read_data && err) begin
            // Corrupted byte: drop it and resync on the next byte
            state_d = ST_IDLE;
        end else if (read_data) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == SC_BREAK) begin
                        state_d = ST_BRK;
                    end else if (rx_data == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (!is_ignored(rx_data)) begin
                        if (rx_data == SC_LSHIFT) begin
                            lshift_d = 1'b1;
                        end else if (rx_data == SC_RSHIFT) begin
                            rshift_d = 1'b1;
                        end else if (rx_data == SC_CAPS) begin
                            // caps_held suppresses re-toggling on typematic repeat
                            if (!caps_held_q) begin
                                caps_lock_d = ~caps_lock_q;
                                caps_held_d = 1'b1;
                            end
                        end else if (map_ascii != 8'h00) begin
                            push = 1'b1;
                        end
                    end
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                    case (rx_data)
                        SC_LSHIFT: lshift_d    = 1'b0;
                        SC_RSHIFT: rshift_d    = 1'b0;
                        SC_CAPS:   caps_held_d = 1'b0;
                        default:   ;
                    endcase
                end
                ST_EXT: begin
                    if (rx_data == SC_BREAK) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        state_d = ST_IDLE;
                        if (rx_data == SC_ENTER) begin
                            push     = 1'b1;
                            push_dat = ASCII_CR;
                        end
                    end
                end
                ST_EXT_BRK: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // FWFT FIFO; the head is registered so out_ascii holds its last value when empty
    always_comb begin
        full            = (count_q == CNT_W'(FIFO_DEPTH));
        pop             = (count_q != '0) && out_ready;
        push_ok         = push && (!full || pop);
        overflow_d      = overflow_q | (push && !push_ok);
        count_after_pop = count_q - CNT_W'(pop);
        count_d         = count_after_pop + CNT_W'(push_ok);
        wr_ptr_d        = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d        = rd_ptr_q + PTR_W'(pop);

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
        end

        head_d = head_q;
        if (count_d != '0) begin
            // If everything older was popped, the new head is the byte written this cycle
            head_d = (count_after_pop == '0) ? push_dat : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            caps_lock_q <= 1'b0;
            caps_held_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_q      <= 8'h00;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            caps_lock_q <= caps_lock_d;
            caps_held_q <= caps_held_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_q      <= head_d;
            mem_q       <= mem_d;
        end
    end

    assign out_ascii    = head_q;
    assign out_valid    = (count_q != '0);
    assign shift_active = lshift_q | rshift_q;
    assign caps_lock    = caps_lock_q;
    assign overflow     = overflow_q;
    assign fifo_count   = count_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Purpose: self-checking bench for ps2_key_decoder: directed scenarios plus random scancode traffic against a queue model.
// Latency: n/a.
// Backpressure: out_ready driven directly and randomly.
module tb_ps2_key_decoder;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       read_data;
    logic       err;
    logic [7:0] out_ascii;
    logic       out_valid;
    logic       out_ready;
    logic       shift_active;
    logic       caps_lock;
    logic       overflow;
    logic [2:0] fifo_count;

    ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .read_data    (read_data),
        .err          (err),
        .out_ascii    (out_ascii),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .shift_active (shift_active),
        .caps_lock    (caps_lock),
        .overflow     (overflow),
        .fifo_count   (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Keyboard-level model: a character queue plus modifier and prefix flags
    logic [7:0] lo_tab [logic [7:0]];
    logic [7:0] hi_tab [logic [7:0]];
    logic [7:0] mq [$];
    logic [7:0] pop_log [$];
    logic [7:0] m_head = 8'h00;
    bit m_lsh = 0, m_rsh = 0, m_caps = 0, m_held = 0, m_ovf = 0, m_f0 = 0, m_e0 = 0;
    logic       dut_vld_s = 1'b0;
    logic [7:0] dut_head_s = 8'h00;

    logic [7:0] let_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                   8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                   8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] dig_codes [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
    logic [7:0] pun_codes [10] = '{8'h4E, 8'h55, 8'h54, 8'h5B, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A, 8'h0E};
    logic [7:0] pool [20] = '{8'h1C, 8'h32, 8'h21, 8'h16, 8'h4E, 8'h29, 8'h5A, 8'h66, 8'h0D, 8'h12,
                              8'h59, 8'h58, 8'hF0, 8'hF0, 8'hE0, 8'hAA, 8'hFA, 8'h75, 8'h52, 8'h1A};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_map(input logic [7:0] c, input bit sh, input bit cp);
        logic [7:0] ch;
        if (!lo_tab.exists(c)) return 0;
        ch = lo_tab[c];
        if (ch >= "a" && ch <= "z") return (sh ^ cp) ? int'(ch) - 32 : int'(ch);
        return sh ? int'(hi_tab[c]) : int'(ch);
    endfunction

    task automatic model_byte(input logic [7:0] b, output int pv);
        pv = -1;
        if (m_e0 && m_f0) begin
            m_e0 = 0; m_f0 = 0;
        end else if (m_e0) begin
            if (b == 8'hF0) m_f0 = 1;
            else begin
                m_e0 = 0;
                if (b == 8'h5A) pv = 8'h0D;
            end
        end else if (m_f0) begin
            m_f0 = 0;
            if (b == 8'h12) m_lsh = 0;
            if (b == 8'h59) m_rsh = 0;
            if (b == 8'h58) m_held = 0;
        end else if (b == 8'hF0) m_f0 = 1;
        else if (b == 8'hE0) m_e0 = 1;
        else if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE}) ;
        else if (b == 8'h12) m_lsh = 1;
        else if (b == 8'h59) m_rsh = 1;
        else if (b == 8'h58) begin
            if (!m_held) begin m_caps = !m_caps; m_held = 1; end
        end else begin
            pv = model_map(b, m_lsh | m_rsh, m_caps);
            if (pv == 0) pv = -1;
        end
    endtask

    // Model step on each active edge
    always @(posedge clk or negedge reset) begin
        int  pv;
        bit  pop;
        if (!reset) begin
            mq.delete();
            m_lsh = 0; m_rsh = 0; m_caps = 0; m_held = 0; m_ovf = 0; m_f0 = 0; m_e0 = 0;
            m_head = 8'h00;
        end else begin
            if (dut_vld_s && out_ready) pop_log.push_back(dut_head_s);
            pop = (mq.size() > 0) && out_ready;
            pv = -1;
            if (read_data) begin
                if (err) begin m_f0 = 0; m_e0 = 0; end
                else model_byte(rx_data, pv);
            end
            if (pop) void'(mq.pop_front());
            if (pv >= 0) begin
                if (mq.size() < DEPTH) mq.push_back(pv[7:0]);
                else m_ovf = 1;
            end
            if (mq.size() > 0) m_head = mq[0];
        end
    end

    // Single compare process, away from the active edge
    always @(negedge clk) begin
        dut_vld_s  = out_valid;
        dut_head_s = out_ascii;
        if (reset) begin
            chk("out_valid",    out_valid,    32'(mq.size() != 0));
            chk("out_ascii",    out_ascii,    m_head);
            chk("fifo_count",   fifo_count,   mq.size());
            chk("shift_active", shift_active, m_lsh | m_rsh);
            chk("caps_lock",    caps_lock,    m_caps);
            chk("overflow",     overflow,     m_ovf);
        end
    end

    task automatic send(input logic [7:0] b, input logic e);
        @(negedge clk); #1;
        rx_data = b; err = e; read_data = 1'b1;
        @(negedge clk); #1;
        read_data = 1'b0; err = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic expect_log(input string name, input logic [7:0] exp[$]);
        chk({name, "_len"}, pop_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < pop_log.size(); i++) chk(name, pop_log[i], exp[i]);
        pop_log.delete();
    endtask

    initial begin
        logic [7:0] e[$];
        string lets, digs, dsh, puns, psh;
        lets = "abcdefghijklmnopqrstuvwxyz";
        digs = "1234567890"; dsh = "!@#$%^&*()";
        puns = "-=[];',./x"; psh = "_+{}:\"<>?~";
        for (int i = 0; i < 26; i++) begin lo_tab[let_codes[i]] = lets[i]; hi_tab[let_codes[i]] = lets[i]; end
        for (int i = 0; i < 10; i++) begin lo_tab[dig_codes[i]] = digs[i]; hi_tab[dig_codes[i]] = dsh[i]; end
        for (int i = 0; i < 10; i++) begin lo_tab[pun_codes[i]] = puns[i]; hi_tab[pun_codes[i]] = psh[i]; end
        lo_tab[8'h0E] = 8'h60;
        lo_tab[8'h29] = 8'h20; hi_tab[8'h29] = 8'h20;
        lo_tab[8'h5A] = 8'h0D; hi_tab[8'h5A] = 8'h0D;
        lo_tab[8'h66] = 8'h08; hi_tab[8'h66] = 8'h08;
        lo_tab[8'h0D] = 8'h09; hi_tab[8'h0D] = 8'h09;

        reset = 1'b0; read_data = 1'b0; rx_data = 8'h00; err = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_ascii", out_ascii, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf",   overflow, 0);
        chk("rst_caps",  caps_lock, 0);
        #1 reset = 1'b1;

        // 1: make, break -> single 'a'
        out_ready = 1'b1;
        send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0); idle(3);
        e = {8'h61}; expect_log("t1", e);
        chk("t1_count", fifo_count, 0);

        // 2: Shift
        send(8'h12, 0);
        chk("t2_shift_on", shift_active, 1);
        send(8'h1C, 0); send(8'hF0, 0); send(8'h12, 0);
        chk("t2_shift_off", shift_active, 0);
        send(8'h1C, 0); idle(3);
        e = {8'h41, 8'h61}; expect_log("t2", e);

        // 3: typematic Caps, digits ignore Caps, Shift XOR Caps
        send(8'h58, 0); send(8'h58, 0); send(8'hF0, 0); send(8'h58, 0);
        chk("t3_caps", caps_lock, 1);
        send(8'h16, 0); send(8'h12, 0); send(8'h1C, 0); send(8'hF0, 0); send(8'h12, 0); idle(3);
        e = {8'h31, 8'h61}; expect_log("t3", e);
        send(8'h58, 0); send(8'hF0, 0); send(8'h58, 0);
        chk("t3_caps_off", caps_lock, 0);

        // 4: extended codes
        send(8'hE0, 0); send(8'h5A, 0); send(8'hE0, 0); send(8'h75, 0);
        send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0); send(8'h1C, 0); idle(3);
        e = {8'h0D, 8'h61}; expect_log("t4", e);

        // 5: fill, overflow, push while full with simultaneous pop
        out_ready = 1'b0;
        send(8'h1C, 0); send(8'h32, 0); send(8'h21, 0); send(8'h23, 0); send(8'h24, 0);
        chk("t5_count_full", fifo_count, 4);
        chk("t5_overflow", overflow, 1);
        @(negedge clk); #1;
        out_ready = 1'b1; rx_data = 8'h2B; read_data = 1'b1;
        @(negedge clk);
        chk("t5_count_pushpop", fifo_count, 4);
        #1 read_data = 1'b0;
        idle(8);
        e = {8'h61, 8'h62, 8'h63, 8'h64, 8'h66}; expect_log("t5", e);

        // 6: err resync, then reset discarding a pending break prefix
        send(8'hF0, 0); send(8'h1C, 1); send(8'h1C, 0); idle(3);
        e = {8'h61}; expect_log("t6a", e);
        send(8'hF0, 0);
        @(negedge clk); #1 reset = 1'b0;
        @(negedge clk); #1 reset = 1'b1;
        chk("t6_ovf_cleared", overflow, 0);
        pop_log.delete();
        send(8'h1C, 0); idle(3);
        e = {8'h61}; expect_log("t6b", e);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk); #1;
            read_data = ($urandom_range(0, 99) < 50);
            rx_data   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 19)];
            err       = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 99) < 60);
        end
        @(negedge clk); #1;
        read_data = 1'b0; err = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
